// File: rtl/qfixed_divider.sv
// qfixed_divider: sequential signed Q-format divider (radix-2 restoring) with rounding,
// saturation to +/-inf and single-cycle special-operand resolution. Rev 1.0
`default_nettype none

module qfixed_divider #(
  parameter int WIDTH = 64,
  parameter int FRAC  = 48,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             launch,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             overflow
);

  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [WIDTH-1:0] NAN_V  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PINF_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NINF_V = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST   = CW'(QW - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [QW-1:0]    dq;     // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] ub;
  logic             neg;

  // Operand classification, evaluated on the launch inputs
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, sgn;
  logic [WIDTH-1:0] special_res, ua, ub_in;

  always_comb begin
    a_nan   = (a == NAN_V);
    b_nan   = (b == NAN_V);
    a_inf   = (a == PINF_V) || (a == NINF_V);
    b_inf   = (b == PINF_V) || (b == NINF_V);
    a_zero  = (a == '0);
    b_zero  = (b == '0);
    special = a_nan || b_nan || b_zero || a_inf || b_inf || a_zero;
    sgn     = a[WIDTH-1] ^ b[WIDTH-1];
    ua      = a[WIDTH-1] ? -a : a;
    ub_in   = b[WIDTH-1] ? -b : b;

    special_res = '0;
    if (a_nan || b_nan || b_zero)
      special_res = NAN_V;
    else if (a_inf && b_inf)
      special_res = NAN_V;
    else if (a_inf)
      special_res = sgn ? NINF_V : PINF_V;
  end

  // One restoring step
  logic [WIDTH:0] rem_sh, rem_nx;
  logic           ge;

  always_comb begin
    rem_sh = {rem[WIDTH-1:0], dq[QW-1]};
    ge     = (rem_sh >= {1'b0, ub});
    rem_nx = ge ? (rem_sh - {1'b0, ub}) : rem_sh;
  end

  // Final rounding, saturation and sign
  logic             rnd, sat;
  logic [QW:0]      q_rnd;
  logic [WIDTH-1:0] mag, fix_res;

  always_comb begin
    rnd     = (ROUND != 0) && ({rem, 1'b0} >= {2'b00, ub});
    q_rnd   = {1'b0, dq} + {{QW{1'b0}}, rnd};
    sat     = (q_rnd >= {{(QW+1-WIDTH){1'b0}}, PINF_V});
    mag     = sat ? PINF_V : q_rnd[WIDTH-1:0];
    fix_res = (neg && (mag != '0)) ? -mag : mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dq       <= '0;
      rem      <= '0;
      ub       <= '0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            if (special) begin
              res      <= special_res;
              overflow <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= '0;
              dq    <= {ua, {FRAC{1'b0}}};
              rem   <= '0;
              ub    <= ub_in;
              neg   <= sgn;
            end
          end
        end
        CALC: begin
          dq  <= {dq[QW-2:0], ge};
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST)
            state <= FIX;
        end
        FIX: begin
          res      <= fix_res;
          overflow <= sat;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
